user_ram_ctrl: RTL

- Bus-side controller sitting directly upstream of the user RAM word store.
- Converts the CPU native memory handshake (valid/ready, 32-bit address, byte write strobes) into the RAM's single-port wr_en/rd_en/addr/di/do interface.
- Handles the RAM's multi-cycle read latency. Implements byte/halfword writes as read-modify-write, because the RAM is word-write only.

---
 rtl/user_ram_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/user_ram_ctrl.sv
// CPU valid/ready memory port to single-port user RAM bridge.
// Multi-cycle reads; sub-word writes become read-modify-write on the word store.
module user_ram_ctrl #(
  parameter int          ADDR_BIT   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0400_0000,
  parameter int          RD_LATENCY = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic                mem_ready_o,
  output logic [31:0]         mem_rdata_o,
  output logic                ram_wr_en_o,
  output logic                ram_rd_en_o,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  output logic [31:0]         ram_di_o,
  input  logic [31:0]         ram_do_i
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    MERGE,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] old_word_q;
  logic [31:0] merged;
  logic        sel;
  logic        accept;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^mem_addr_i[1:0];
  assign sel    = (mem_addr_i[31:ADDR_BIT+2] == BASE_ADDR[31:ADDR_BIT+2]);
  assign accept = (state_q == IDLE) && mem_valid_i && sel;

  // The word read back during RD_WAIT doubles as the CPU read data and the merge source.
  assign mem_rdata_o = old_word_q;

  always_comb begin
    merged = old_word_q;
    for (int b = 0; b < 4; b++) begin
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_wr_en_o = 1'b0;
    ram_rd_en_o = 1'b0;
    ram_di_o    = 32'h0;
    mem_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (mem_wstrb_i == 4'hF) ? WRITE : RD_WAIT;
      end
      WRITE: begin
        ram_wr_en_o = 1'b1;
        ram_di_o    = wdata_q;
        state_d     = RESP;
      end
      RD_WAIT: begin
        ram_rd_en_o = 1'b1;
        if (cnt_q == 4'd1) state_d = (wstrb_q == 4'h0) ? RESP : MERGE;
      end
      MERGE: begin
        ram_wr_en_o = 1'b1;
        ram_di_o    = merged;
        state_d     = RESP;
      end
      RESP: begin
        mem_ready_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are latched once at acceptance so the bus is free to change afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ram_addr_o <= '0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      old_word_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ram_addr_o <= mem_addr_i[ADDR_BIT+1:2];
        wdata_q    <= mem_wdata_i;
        wstrb_q    <= mem_wstrb_i;
        cnt_q      <= 4'(RD_LATENCY);
      end else if (state_q == RD_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) old_word_q <= ram_do_i;
      end
    end
  end

endmodule
